uart_cmd_ctrl: RTL
==================

// Module: uart_cmd_ctrl
// PURPOSE
//  Command sequencer between the UART and the register file / ALU. Decodes byte frames
//  arriving from UART RX (already synchronised into CLK domain), issues register
//  writes/reads and ALU operations, and queues response bytes toward UART TX (TX FIFO).
//  Controls the ALU clock-gate enable. Single clock domain.
// PARAMETERS
//  DATA_WIDTH    8  byte width of UART frames, register data
//  ADDR_WIDTH    4  register-file address width (addr = low ADDR_WIDTH bits of byte)
//  FUN_WIDTH     4  ALU function code width (low FUN_WIDTH bits of byte)
// PORTS
//  CLK          in   1             system clock
//  RST          in   1             asynchronous reset, active-low
//  RX_P_DATA    in   DATA_WIDTH    received byte
//  RX_D_VLD     in   1             1-cycle pulse: RX_P_DATA valid
//  RF_RD_DATA   in   DATA_WIDTH    register-file read data
//  RF_RD_VLD    in   1             1-cycle pulse: RF_RD_DATA valid
//  ALU_OUT      in   2*DATA_WIDTH  ALU result
//  ALU_OUT_VLD  in   1             1-cycle pulse: ALU_OUT valid
//  TX_FIFO_FULL in   1             TX FIFO cannot accept a write
//  RF_WR_EN     out  1             register write strobe (1 cycle)
//  RF_RD_EN     out  1             register read strobe (1 cycle)
//  RF_ADDR      out  ADDR_WIDTH    register address
//  RF_WR_DATA   out  DATA_WIDTH    register write data
//  ALU_EN       out  1             ALU operation enable (1 cycle)
//  ALU_FUN      out  FUN_WIDTH     ALU function code
//  ALU_CLK_EN   out  1             ALU clock-gate enable
//  TX_P_DATA    out  DATA_WIDTH    byte to TX FIFO
//  TX_D_VLD     out  1             TX FIFO write strobe (1 cycle per byte)
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE. Strobe outputs are registered, high exactly 1 cycle.
//  Commands (first byte, decoded in IDLE on RX_D_VLD; other values ignored, stay IDLE):
//   0xAA WR : ADDR, DATA        -> RF_WR_EN with ADDR/DATA the cycle after DATA byte
//   0xBB RD : ADDR              -> RF_RD_EN; await RF_RD_VLD; send 1 byte
//   0xCC ALU: A, B, FUN         -> write A to addr 0, B to addr 1 (RF_WR_EN each), then op
//   0xDD ALU: FUN               -> op on current regs 0/1
//  States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, OP_FUN, ALU_WAIT,
//   SEND_LO, SEND_HI. Each byte state advances only on RX_D_VLD.
//  ALU op: on FUN byte, ALU_CLK_EN=1 and ALU_EN pulse with ALU_FUN in the next cycle;
//   ALU_CLK_EN stays 1 until ALU_OUT_VLD; result latched; ALU_CLK_EN drops next cycle.
//  Responses: result latched internally; SEND_LO writes ALU_OUT[7:0] (or RD data),
//   SEND_HI writes ALU_OUT[15:8]. A byte is written (TX_D_VLD=1) only in a cycle where
//   TX_FIFO_FULL=0; otherwise state holds, data held stable. RD sends LO only.
//   After last byte written -> IDLE next cycle.
//  RX_D_VLD during RD_WAIT/ALU_WAIT/SEND_*: byte dropped (no buffering).
//  Back-to-back: a new command byte is accepted the cycle after returning to IDLE.
//  RF_ADDR/RF_WR_DATA/ALU_FUN hold last value between strobes.
//  RST low mid-command: immediate return to IDLE, strobes and ALU_CLK_EN cleared.
// TESTING
//  WR: AA,05,3C -> one RF_WR_EN pulse, RF_ADDR=5, RF_WR_DATA=3C; no TX_D_VLD.
//  RD: BB,07, RF_RD_DATA=5A -> one RF_RD_EN (ADDR=7), then TX_D_VLD with 5A.
//  ALU: CC,12,34,00, ALU_OUT=0046 -> writes 12@0,34@1, ALU_EN FUN=0, TX bytes 46 then 00.
//  Backpressure: DD,02 with TX_FIFO_FULL=1 for 5 cycles -> no TX_D_VLD until released,
//   then LO,HI in order, exactly one strobe each.
//  Bad opcode 0x11 then AA,01,FF -> 0x11 ignored, write to addr 1 = FF occurs.
//  Reset asserted in ALU_WAIT -> all outputs 0; next BB,00 executes normally.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: decodes UART command frames into register-file writes/reads and ALU ops,
// and returns read data or ALU results to the TX FIFO.
module uart_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   rx_p_data_i,
  input  logic                    rx_d_vld_i,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data_i,
  input  logic                    rf_rd_vld_i,
  input  logic [2*DATA_WIDTH-1:0] alu_out_i,
  input  logic                    alu_out_vld_i,
  input  logic                    tx_fifo_full_i,
  output logic                    rf_wr_en_o,
  output logic                    rf_rd_en_o,
  output logic [ADDR_WIDTH-1:0]   rf_addr_o,
  output logic [DATA_WIDTH-1:0]   rf_wr_data_o,
  output logic                    alu_en_o,
  output logic [FUN_WIDTH-1:0]    alu_fun_o,
  output logic                    alu_clk_en_o,
  output logic [DATA_WIDTH-1:0]   tx_p_data_o,
  output logic                    tx_d_vld_o
);
  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_AB = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, OP_FUN, ALU_WAIT, SEND_LO, SEND_HI
  } state_t;

  state_t                  state_q, state_d;
  logic                    wr_en_q, wr_en_d, rd_en_q, rd_en_d, alu_en_q, alu_en_d;
  logic                    clk_en_q, clk_en_d, rd_only_q, rd_only_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [FUN_WIDTH-1:0]    fun_q, fun_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    clk_en_d  = clk_en_q;
    rd_only_d = rd_only_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    fun_d     = fun_q;
    res_d     = res_q;
    case (state_q)
      IDLE: if (rx_d_vld_i)
        state_d = rx_p_data_i == CMD_WR     ? WR_ADDR :
                  rx_p_data_i == CMD_RD     ? RD_ADDR :
                  rx_p_data_i == CMD_ALU_AB ? OP_A    :
                  rx_p_data_i == CMD_ALU    ? OP_FUN  : IDLE;
      WR_ADDR: if (rx_d_vld_i) begin
        addr_d  = rx_p_data_i[ADDR_WIDTH-1:0];
        state_d = WR_DATA;
      end
      WR_DATA: if (rx_d_vld_i) begin
        wr_data_d = rx_p_data_i;
        wr_en_d   = 1'b1;
        state_d   = IDLE;
      end
      RD_ADDR: if (rx_d_vld_i) begin
        addr_d  = rx_p_data_i[ADDR_WIDTH-1:0];
        rd_en_d = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: if (rf_rd_vld_i) begin
        res_d     = {{DATA_WIDTH{1'b0}}, rf_rd_data_i};
        rd_only_d = 1'b1;
        state_d   = SEND_LO;
      end
      // Operands A and B always land in registers 0 and 1.
      OP_A: if (rx_d_vld_i) begin
        addr_d    = '0;
        wr_data_d = rx_p_data_i;
        wr_en_d   = 1'b1;
        state_d   = OP_B;
      end
      OP_B: if (rx_d_vld_i) begin
        addr_d    = ADDR_WIDTH'(1);
        wr_data_d = rx_p_data_i;
        wr_en_d   = 1'b1;
        state_d   = OP_FUN;
      end
      OP_FUN: if (rx_d_vld_i) begin
        fun_d    = rx_p_data_i[FUN_WIDTH-1:0];
        alu_en_d = 1'b1;
        clk_en_d = 1'b1;
        state_d  = ALU_WAIT;
      end
      ALU_WAIT: if (alu_out_vld_i) begin
        res_d     = alu_out_i;
        rd_only_d = 1'b0;
        clk_en_d  = 1'b0;
        state_d   = SEND_LO;
      end
      SEND_LO: if (!tx_fifo_full_i) state_d = rd_only_q ? IDLE : SEND_HI;
      SEND_HI: if (!tx_fifo_full_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      clk_en_q  <= 1'b0;
      rd_only_q <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      fun_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      alu_en_q  <= alu_en_d;
      clk_en_q  <= clk_en_d;
      rd_only_q <= rd_only_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      fun_q     <= fun_d;
      res_q     <= res_d;
    end
  end

  // TX strobe qualifies the held send state with the live FIFO status so no byte hits a full FIFO.
  assign tx_d_vld_o   = (state_q == SEND_LO || state_q == SEND_HI) && !tx_fifo_full_i;
  assign tx_p_data_o  = state_q == SEND_HI ? res_q[2*DATA_WIDTH-1:DATA_WIDTH] : res_q[DATA_WIDTH-1:0];
  assign rf_wr_en_o   = wr_en_q;
  assign rf_rd_en_o   = rd_en_q;
  assign rf_addr_o    = addr_q;
  assign rf_wr_data_o = wr_data_q;
  assign alu_en_o     = alu_en_q;
  assign alu_fun_o    = fun_q;
  assign alu_clk_en_o = clk_en_q;
endmodule
